// File: rtl/lens_table_editor.sv
// lens_table_editor: button-driven lens preview plus working/display lens tables swapped on frame_tick.
// Define LENS_OVERLAP_CHECK_EN to reject commits that overlap an existing lens (adds the CHECK state).
module lens_table_editor #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240,
   parameter int MAX_LENS   = 8,
   parameter int POS_STEP   = 2,
   parameter int R_MIN      = 8,
   parameter int R_MAX      = 120,
   parameter int R_STEP     = 2,
   parameter int R_DEFAULT  = 40,
   parameter int K_MAX      = 15,
   parameter int K_DEFAULT  = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              frame_tick,
   input  logic                              sw0_edit_mode,
   input  logic                              sw_size_mode,
   input  logic                              btn_up,
   input  logic                              btn_down,
   input  logic                              btn_left,
   input  logic                              btn_right,
   input  logic                              btn_commit,
   input  logic                              btn_undo,
   input  logic                              btn_clear,
   output logic [8:0]                        current_center_x,
   output logic [7:0]                        current_center_y,
   output logic [7:0]                        current_R,
   output logic [7:0]                        current_K,
   output logic                              preview_enable,
   output logic [$clog2(MAX_LENS+1)-1:0]     lens_count,
   output logic [8:0]                        lens_center_x [0:MAX_LENS-1],
   output logic [7:0]                        lens_center_y [0:MAX_LENS-1],
   output logic [7:0]                        lens_R [0:MAX_LENS-1],
   output logic [7:0]                        lens_K [0:MAX_LENS-1],
   output logic                              busy,
   output logic                              commit_reject
);
   localparam int CW = $clog2(MAX_LENS + 1);
   localparam int IW = (MAX_LENS > 1) ? $clog2(MAX_LENS) : 1;
   localparam logic [CW-1:0] FULL = CW'(MAX_LENS);
   localparam logic [IW-1:0] LAST = IW'(MAX_LENS - 1);
   localparam logic [8:0] X_MAX = 9'(IMG_WIDTH - 1);
   localparam logic [8:0] P9 = 9'(POS_STEP);
   localparam logic [7:0] Y_MAX = 8'(IMG_HEIGHT - 1);
   localparam logic [7:0] P8 = 8'(POS_STEP);
   localparam logic [7:0] RMIN = 8'(R_MIN);
   localparam logic [7:0] RMAX = 8'(R_MAX);
   localparam logic [7:0] RS = 8'(R_STEP);
   localparam logic [7:0] KMAX = 8'(K_MAX);
`ifdef LENS_OVERLAP_CHECK_EN
   typedef enum logic [1:0] {IDLE, CLEAR, CHECK} state_t;
`else
   typedef enum logic [1:0] {IDLE, CLEAR} state_t;
`endif
   state_t state, state_n;
   logic [8:0] w_x [0:MAX_LENS-1];
   logic [7:0] w_y [0:MAX_LENS-1];
   logic [7:0] w_r [0:MAX_LENS-1];
   logic [7:0] w_k [0:MAX_LENS-1];
   logic [CW-1:0] wcount;
   logic [IW-1:0] idx;
   logic up_p, down_p, left_p, right_p, sync_pending;
   logic idle, do_clear, do_undo, do_commit, can_commit, copy;
   logic mv_u, mv_d, mv_l, mv_r;
   logic [8:0] x_n;
   logic [7:0] y_n, r_n, k_n;
`ifdef LENS_OVERLAP_CHECK_EN
   logic [8:0] c_x;
   logic [7:0] c_y, c_r, c_k;
   logic ovl, hit, chk_end;
   logic [9:0] dx, dy, rs;
   always_comb begin
      dx = (c_x >= w_x[idx]) ? {1'b0, c_x - w_x[idx]} : {1'b0, w_x[idx] - c_x};
      dy = (c_y >= w_y[idx]) ? {2'b0, c_y - w_y[idx]} : {2'b0, w_y[idx] - c_y};
      rs = {2'b0, c_r} + {2'b0, w_r[idx]};
      hit = (CW'(idx) < wcount) && (dx < rs) && (dy < rs);
      chk_end = (wcount == '0) || (CW'(idx) == wcount - 1'b1);
   end
`endif
   // Opposing pending flags cancel; the switch selects which registers the arrows steer.
   always_comb begin
      mv_u = up_p & ~down_p;
      mv_d = down_p & ~up_p;
      mv_l = left_p & ~right_p;
      mv_r = right_p & ~left_p;
      x_n = (~sw_size_mode & mv_r) ? ((current_center_x >= X_MAX - P9) ? X_MAX : current_center_x + P9)
          : (~sw_size_mode & mv_l) ? ((current_center_x < P9) ? 9'd0 : current_center_x - P9) : current_center_x;
      y_n = (~sw_size_mode & mv_u) ? ((current_center_y < P8) ? 8'd0 : current_center_y - P8)
          : (~sw_size_mode & mv_d) ? ((current_center_y >= Y_MAX - P8) ? Y_MAX : current_center_y + P8) : current_center_y;
      r_n = (sw_size_mode & mv_u) ? ((current_R >= RMAX - RS) ? RMAX : current_R + RS)
          : (sw_size_mode & mv_d) ? ((current_R <= RMIN + RS) ? RMIN : current_R - RS) : current_R;
      k_n = (sw_size_mode & mv_r) ? ((current_K >= KMAX) ? KMAX : current_K + 8'd1)
          : (sw_size_mode & mv_l) ? ((current_K == 8'd0) ? 8'd0 : current_K - 8'd1) : current_K;
   end
   always_comb begin
      idle = (state == IDLE);
      do_clear = idle & btn_clear;
      do_undo = idle & ~btn_clear & btn_undo & (wcount != '0);
      do_commit = idle & ~btn_clear & ~btn_undo & btn_commit;
      can_commit = sw0_edit_mode & (wcount < FULL);
      copy = idle & (frame_tick | sync_pending);
   end
   always_ff @(posedge clk) begin
      if (!reset) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = state;
      case (state)
`ifdef LENS_OVERLAP_CHECK_EN
         IDLE: state_n = do_clear ? CLEAR : (do_commit & can_commit) ? CHECK : IDLE;
         CHECK: state_n = chk_end ? IDLE : CHECK;
`else
         IDLE: state_n = do_clear ? CLEAR : IDLE;
`endif
         CLEAR: state_n = (idx == LAST) ? IDLE : CLEAR;
         default: state_n = IDLE;
      endcase
   end
   always_comb begin
      busy = (state != IDLE);
   end
   always_ff @(posedge clk) begin
      if (!reset) begin
         current_center_x <= 9'(IMG_WIDTH / 2);
         current_center_y <= 8'(IMG_HEIGHT / 2);
         current_R <= 8'(R_DEFAULT);
         current_K <= 8'(K_DEFAULT);
         preview_enable <= 1'b0;
         commit_reject <= 1'b0;
         lens_count <= '0;
         wcount <= '0;
         idx <= '0;
         {up_p, down_p, left_p, right_p, sync_pending} <= '0;
         for (int i = 0; i < MAX_LENS; i++) begin
            w_x[i] <= '0;
            w_y[i] <= '0;
            w_r[i] <= '0;
            w_k[i] <= '0;
            lens_center_x[i] <= '0;
            lens_center_y[i] <= '0;
            lens_R[i] <= '0;
            lens_K[i] <= '0;
         end
`ifdef LENS_OVERLAP_CHECK_EN
         {c_x, c_y, c_r, c_k, ovl} <= '0;
`endif
      end else begin
         commit_reject <= ~idle & btn_commit;
         up_p <= (up_p & ~frame_tick) | (sw0_edit_mode & btn_up);
         down_p <= (down_p & ~frame_tick) | (sw0_edit_mode & btn_down);
         left_p <= (left_p & ~frame_tick) | (sw0_edit_mode & btn_left);
         right_p <= (right_p & ~frame_tick) | (sw0_edit_mode & btn_right);
         sync_pending <= ~idle & (sync_pending | frame_tick);
         if (frame_tick) begin
            preview_enable <= sw0_edit_mode;
            current_center_x <= x_n;
            current_center_y <= y_n;
            current_R <= r_n;
            current_K <= k_n;
         end
         // Copy sees the working table as it stood before any same-cycle command.
         if (copy) begin
            lens_count <= wcount;
            for (int i = 0; i < MAX_LENS; i++) begin
               lens_center_x[i] <= (CW'(i) < wcount) ? w_x[i] : '0;
               lens_center_y[i] <= (CW'(i) < wcount) ? w_y[i] : '0;
               lens_R[i] <= (CW'(i) < wcount) ? w_r[i] : '0;
               lens_K[i] <= (CW'(i) < wcount) ? w_k[i] : '0;
            end
         end
         if (do_clear) idx <= '0;
         else if (do_undo) begin
            wcount <= wcount - 1'b1;
            w_x[IW'(wcount - 1'b1)] <= '0;
            w_y[IW'(wcount - 1'b1)] <= '0;
            w_r[IW'(wcount - 1'b1)] <= '0;
            w_k[IW'(wcount - 1'b1)] <= '0;
         end else if (do_commit & ~can_commit) commit_reject <= 1'b1;
         else if (do_commit) begin
`ifdef LENS_OVERLAP_CHECK_EN
            {c_x, c_y, c_r, c_k} <= {current_center_x, current_center_y, current_R, current_K};
            ovl <= 1'b0;
            idx <= '0;
`else
            w_x[wcount[IW-1:0]] <= current_center_x;
            w_y[wcount[IW-1:0]] <= current_center_y;
            w_r[wcount[IW-1:0]] <= current_R;
            w_k[wcount[IW-1:0]] <= current_K;
            wcount <= wcount + 1'b1;
`endif
         end
         if (state == CLEAR) begin
            w_x[idx] <= '0;
            w_y[idx] <= '0;
            w_r[idx] <= '0;
            w_k[idx] <= '0;
            idx <= idx + 1'b1;
            if (idx == LAST) wcount <= '0;
         end
`ifdef LENS_OVERLAP_CHECK_EN
         if (state == CHECK) begin
            ovl <= ovl | hit;
            idx <= idx + 1'b1;
            if (chk_end && (ovl | hit)) commit_reject <= 1'b1;
            else if (chk_end) begin
               w_x[wcount[IW-1:0]] <= c_x;
               w_y[wcount[IW-1:0]] <= c_y;
               w_r[wcount[IW-1:0]] <= c_r;
               w_k[wcount[IW-1:0]] <= c_k;
               wcount <= wcount + 1'b1;
            end
         end
`endif
      end
   end
endmodule

// File: tb/tb_lens_table_editor.sv
// tb_lens_table_editor: randomized and directed checks of lens_table_editor against a queue-based model.
module tb_lens_table_editor;
   localparam int ML = 8;
   logic clk = 1'b0;
   logic reset, frame_tick, sw0_edit_mode, sw_size_mode;
   logic btn_up, btn_down, btn_left, btn_right, btn_commit, btn_undo, btn_clear;
   logic [8:0] current_center_x;
   logic [7:0] current_center_y, current_R, current_K;
   logic preview_enable, busy, commit_reject;
   logic [3:0] lens_count;
   logic [8:0] lens_center_x [0:ML-1];
   logic [7:0] lens_center_y [0:ML-1];
   logic [7:0] lens_R [0:ML-1];
   logic [7:0] lens_K [0:ML-1];
   int checks = 0;
   int errors = 0;

   typedef struct {int x; int y; int r; int k;} lens_t;
   lens_t wt[$];
   lens_t disp[$];
   int mx, my, mr, mk, mbusy;
   bit mprev, msync, mrej, fu, fd, fl, fr;

   lens_table_editor dut (
      .clk(clk), .reset(reset), .frame_tick(frame_tick), .sw0_edit_mode(sw0_edit_mode),
      .sw_size_mode(sw_size_mode), .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
      .btn_right(btn_right), .btn_commit(btn_commit), .btn_undo(btn_undo), .btn_clear(btn_clear),
      .current_center_x(current_center_x), .current_center_y(current_center_y),
      .current_R(current_R), .current_K(current_K), .preview_enable(preview_enable),
      .lens_count(lens_count), .lens_center_x(lens_center_x), .lens_center_y(lens_center_y),
      .lens_R(lens_R), .lens_K(lens_K), .busy(busy), .commit_reject(commit_reject)
   );

   always #5 clk = ~clk;

   function automatic int clamp(int v, int lo, int hi);
      return (v < lo) ? lo : (v > hi) ? hi : v;
   endfunction

   task automatic model_reset();
      mx = 160; my = 120; mr = 40; mk = 4; mbusy = 0;
      {mprev, msync, mrej, fu, fd, fl, fr} = '0;
      wt.delete();
      disp.delete();
   endtask

   // Frame-level rules: table as a queue, clear as an 8-cycle busy window, moves as clamped arithmetic.
   task automatic model_update();
      bit bz;
      lens_t e;
      bz = mbusy > 0;
      mrej = 0;
      if (!bz && (frame_tick || msync)) disp = wt;
      msync = bz && (msync || frame_tick);
      if (bz) begin
         mrej = btn_commit;
         mbusy--;
         if (mbusy == 0) wt.delete();
      end else if (btn_clear) mbusy = ML;
      else if (btn_undo) begin
         if (wt.size() > 0) void'(wt.pop_back());
      end else if (btn_commit) begin
         if (sw0_edit_mode && wt.size() < ML) begin
            e = '{mx, my, mr, mk};
            wt.push_back(e);
         end else mrej = 1;
      end
      if (frame_tick) begin
         if (sw_size_mode) begin
            if (fu && !fd) mr = clamp(mr + 2, 8, 120);
            if (fd && !fu) mr = clamp(mr - 2, 8, 120);
            if (fr && !fl) mk = clamp(mk + 1, 0, 15);
            if (fl && !fr) mk = clamp(mk - 1, 0, 15);
         end else begin
            if (fr && !fl) mx = clamp(mx + 2, 0, 319);
            if (fl && !fr) mx = clamp(mx - 2, 0, 319);
            if (fu && !fd) my = clamp(my - 2, 0, 239);
            if (fd && !fu) my = clamp(my + 2, 0, 239);
         end
         mprev = sw0_edit_mode;
      end
      fu = (fu && !frame_tick) || (sw0_edit_mode && btn_up);
      fd = (fd && !frame_tick) || (sw0_edit_mode && btn_down);
      fl = (fl && !frame_tick) || (sw0_edit_mode && btn_left);
      fr = (fr && !frame_tick) || (sw0_edit_mode && btn_right);
   endtask

   task automatic step();
      if (!reset) model_reset();
      else model_update();
      @(posedge clk);
      #1;
      {frame_tick, btn_up, btn_down, btn_left, btn_right, btn_commit, btn_undo, btn_clear} = '0;
   endtask

   task automatic tick();
      frame_tick = 1;
      step();
   endtask

   task automatic test_reset();
      reset = 0;
      repeat (3) step();
      reset = 1;
      checks++; if (current_center_x !== 9'd160) begin errors++; $display("FAIL reset_x got %0d want 160", current_center_x); end
      checks++; if (current_center_y !== 8'd120) begin errors++; $display("FAIL reset_y got %0d want 120", current_center_y); end
      checks++; if (current_R !== 8'd40) begin errors++; $display("FAIL reset_R got %0d want 40", current_R); end
      checks++; if (current_K !== 8'd4) begin errors++; $display("FAIL reset_K got %0d want 4", current_K); end
      checks++; if (lens_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", lens_count); end
      checks++; if ({preview_enable, busy, commit_reject} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {preview_enable, busy, commit_reject}); end
      for (int i = 0; i < ML; i++) begin
         checks++;
         if ({lens_center_x[i], lens_center_y[i], lens_R[i], lens_K[i]} !== '0) begin
            errors++; $display("FAIL reset_entry%0d got %h want 0", i, {lens_center_x[i], lens_center_y[i], lens_R[i], lens_K[i]});
         end
      end
   endtask

   task automatic test_move();
      sw0_edit_mode = 1; sw_size_mode = 0;
      tick();
      checks++; if (preview_enable !== 1'b1) begin errors++; $display("FAIL preview_on got %b want 1", preview_enable); end
      btn_right = 1; step(); tick();
      checks++; if (current_center_x !== 9'd162) begin errors++; $display("FAIL move_right got %0d want 162", current_center_x); end
      sw0_edit_mode = 0; btn_right = 1; step();
      sw0_edit_mode = 1; tick();
      checks++; if (current_center_x !== 9'd162) begin errors++; $display("FAIL edit_off_drop got %0d want 162", current_center_x); end
      while (mx < 318) begin btn_right = 1; step(); tick(); end
      checks++; if (current_center_x !== 9'd318) begin errors++; $display("FAIL move_318 got %0d want 318", current_center_x); end
      for (int n = 0; n < 2; n++) begin
         btn_right = 1; step(); tick();
         checks++; if (current_center_x !== 9'd319) begin errors++; $display("FAIL sat_x%0d got %0d want 319", n, current_center_x); end
      end
      btn_up = 1; btn_down = 1; step(); tick();
      checks++; if (current_center_y !== 8'd120) begin errors++; $display("FAIL cancel_ud got %0d want 120", current_center_y); end
      btn_up = 1; step(); tick();
      checks++; if (current_center_y !== 8'(my)) begin errors++; $display("FAIL move_up got %0d want %0d", current_center_y, my); end
   endtask

   task automatic test_commit_full();
      for (int n = 0; n < ML; n++) begin
         btn_left = 1'($urandom % 2); btn_up = 1'($urandom % 2); btn_down = 1'($urandom % 2);
         step(); tick();
         btn_commit = 1; step();
         checks++; if (commit_reject !== 1'b0) begin errors++; $display("FAIL commit%0d_rej got %b want 0", n, commit_reject); end
      end
      checks++; if (lens_count !== 4'd7) begin errors++; $display("FAIL count_before_tick got %0d want 7", lens_count); end
      tick();
      checks++; if (lens_count !== 4'd8) begin errors++; $display("FAIL count_full got %0d want 8", lens_count); end
      for (int i = 0; i < ML; i++) begin
         checks++;
         if (lens_center_x[i] !== 9'(disp[i].x) || lens_center_y[i] !== 8'(disp[i].y) || lens_R[i] !== 8'(disp[i].r) || lens_K[i] !== 8'(disp[i].k)) begin
            errors++; $display("FAIL entry%0d got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", i, lens_center_x[i], lens_center_y[i], lens_R[i], lens_K[i], disp[i].x, disp[i].y, disp[i].r, disp[i].k);
         end
      end
      btn_commit = 1; step();
      checks++; if (commit_reject !== 1'b1) begin errors++; $display("FAIL full_reject got %b want 1", commit_reject); end
      step();
      checks++; if (commit_reject !== 1'b0) begin errors++; $display("FAIL reject_pulse got %b want 0", commit_reject); end
      tick();
      checks++; if (lens_count !== 4'd8) begin errors++; $display("FAIL count_after_reject got %0d want 8", lens_count); end
      btn_undo = 1; step(); tick();
      checks++; if (lens_count !== 4'd7) begin errors++; $display("FAIL undo_count got %0d want 7", lens_count); end
      checks++;
      if ({lens_center_x[7], lens_center_y[7], lens_R[7], lens_K[7]} !== '0) begin
         errors++; $display("FAIL undo_entry7 got %h want 0", {lens_center_x[7], lens_center_y[7], lens_R[7], lens_K[7]});
      end
   endtask

   task automatic test_clear();
      int busy_n, fall;
      busy_n = 0; fall = -1;
      btn_clear = 1; step();
      for (int c = 0; c < 12; c++) begin
         if (busy) begin
            busy_n++;
            checks++; if (lens_count !== 4'd7) begin errors++; $display("FAIL busy_display c%0d got %0d want 7", c, lens_count); end
         end else if (fall < 0) begin
            fall = c;
            checks++; if (lens_count !== 4'd7) begin errors++; $display("FAIL first_idle_display got %0d want 7", lens_count); end
         end else if (c == fall + 1) begin
            checks++; if (lens_count !== 4'd0) begin errors++; $display("FAIL deferred_sync got %0d want 0", lens_count); end
         end
         if (c == 4) begin
            checks++; if (commit_reject !== 1'b1) begin errors++; $display("FAIL busy_commit_rej got %b want 1", commit_reject); end
         end
         if (c == 1) frame_tick = 1;
         if (c == 3) btn_commit = 1;
         step();
      end
      checks++; if (busy_n != ML) begin errors++; $display("FAIL busy_cycles got %0d want %0d", busy_n, ML); end
      checks++; if (lens_count !== 4'(disp.size())) begin errors++; $display("FAIL clear_model got %0d want %0d", lens_count, disp.size()); end
   endtask

   task automatic test_size();
      sw0_edit_mode = 1; sw_size_mode = 1;
      for (int n = 0; n < 60; n++) begin btn_up = 1; step(); tick(); end
      checks++; if (current_R !== 8'd120) begin errors++; $display("FAIL R_max got %0d want 120", current_R); end
      for (int n = 0; n < 5; n++) begin btn_left = 1; step(); tick(); end
      checks++; if (current_K !== 8'd0) begin errors++; $display("FAIL K_zero got %0d want 0", current_K); end
      btn_left = 1; step(); tick();
      checks++; if (current_K !== 8'd0) begin errors++; $display("FAIL K_floor got %0d want 0", current_K); end
      for (int n = 0; n < 60; n++) begin btn_down = 1; step(); tick(); end
      checks++; if (current_R !== 8'd8) begin errors++; $display("FAIL R_min got %0d want 8", current_R); end
      for (int n = 0; n < 20; n++) begin btn_right = 1; step(); tick(); end
      checks++; if (current_K !== 8'd15) begin errors++; $display("FAIL K_max got %0d want 15", current_K); end
      sw_size_mode = 0;
   endtask

   task automatic test_random();
      for (int c = 0; c < 800; c++) begin
         frame_tick = ($urandom % 12) == 0;
         btn_up = ($urandom % 6) == 0; btn_down = ($urandom % 6) == 0;
         btn_left = ($urandom % 6) == 0; btn_right = ($urandom % 6) == 0;
         btn_commit = ($urandom % 5) == 0; btn_undo = ($urandom % 10) == 0; btn_clear = ($urandom % 60) == 0;
         if ($urandom % 50 == 0) sw0_edit_mode = ~sw0_edit_mode;
         if ($urandom % 40 == 0) sw_size_mode = ~sw_size_mode;
         step();
         checks++;
         if (current_center_x !== 9'(mx) || current_center_y !== 8'(my) || current_R !== 8'(mr) || current_K !== 8'(mk)) begin
            errors++; $display("FAIL rnd_current c%0d got (%0d,%0d,%0d,%0d) want (%0d,%0d,%0d,%0d)", c, current_center_x, current_center_y, current_R, current_K, mx, my, mr, mk);
         end
         checks++;
         if ({preview_enable, busy, commit_reject} !== {mprev, mbusy > 0, mrej}) begin
            errors++; $display("FAIL rnd_flags c%0d got %b want %b", c, {preview_enable, busy, commit_reject}, {mprev, mbusy > 0, mrej});
         end
         checks++; if (lens_count !== 4'(disp.size())) begin errors++; $display("FAIL rnd_count c%0d got %0d want %0d", c, lens_count, disp.size()); end
         for (int i = 0; i < ML; i++) begin
            checks++;
            if (i < disp.size() ? (lens_center_x[i] !== 9'(disp[i].x) || lens_center_y[i] !== 8'(disp[i].y) || lens_R[i] !== 8'(disp[i].r) || lens_K[i] !== 8'(disp[i].k))
                                : ({lens_center_x[i], lens_center_y[i], lens_R[i], lens_K[i]} !== '0)) begin
               errors++; $display("FAIL rnd_entry c%0d i%0d got (%0d,%0d,%0d,%0d) want size %0d", c, i, lens_center_x[i], lens_center_y[i], lens_R[i], lens_K[i], disp.size());
            end
         end
      end
   endtask

`ifdef LENS_OVERLAP_CHECK_EN
   task automatic test_overlap();
      bit rej;
      int n;
      sw0_edit_mode = 1; sw_size_mode = 0;
      tick();
      repeat (30) begin btn_left = 1; step(); tick(); end
      repeat (10) begin btn_up = 1; step(); tick(); end
      for (int t = 0; t < 3; t++) begin
         if (t > 0) repeat (25) begin btn_right = 1; step(); tick(); end
         rej = 0; n = 0;
         btn_commit = 1; step();
         while (busy && n < 20) begin rej |= commit_reject; step(); n++; end
         rej |= commit_reject;
         checks++; if (n >= 20) begin errors++; $display("FAIL check_timeout t%0d got busy want idle", t); end
         checks++; if (rej !== (t == 1)) begin errors++; $display("FAIL overlap_t%0d got rej %b want %b", t, rej, t == 1); end
      end
      tick();
      checks++; if (lens_count !== 4'd2) begin errors++; $display("FAIL overlap_count got %0d want 2", lens_count); end
   endtask
`endif

   initial begin
      {reset, frame_tick, sw0_edit_mode, sw_size_mode} = '0;
      {btn_up, btn_down, btn_left, btn_right, btn_commit, btn_undo, btn_clear} = '0;
      test_reset();
`ifdef LENS_OVERLAP_CHECK_EN
      test_overlap();
`else
      test_move();
      test_commit_full();
      test_clear();
      test_size();
      test_random();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lens_table_editor.md
Name: lens_table_editor

Overview:
- Producer side of the lens-parameter interface that the convex lens address filter consumes.
- Turns debounced button pulses and the edit switch into a preview lens (`current_*`) and a committed lens table (`lens_*`, `lens_count`).
- Holds a working table plus a frame-synchronous display table, so the filter never sees a parameter change mid-frame.
- Sits between the button debouncers/VGA timing and the filter, in the `clk` domain.

Parameters:
- IMG_WIDTH, 320, image width in pixels.
- IMG_HEIGHT, 240, image height in pixels.
- MAX_LENS, 8, table capacity.
- POS_STEP, 2, centre move per frame tick, in pixels.
- R_MIN, 8, minimum radius.
- R_MAX, 120, maximum radius.
- R_STEP, 2, radius change per frame tick.
- R_DEFAULT, 40, reset/preset radius.
- K_MAX, 15, maximum strength.
- K_DEFAULT, 4, reset/preset strength.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset (0 = reset).
- frame_tick  in  1  one-cycle pulse at start of vertical blank.
- sw0_edit_mode  in  1  edit switch (already synchronised).
- sw_size_mode  in  1  0: arrow buttons move the centre; 1: up/down change R, left/right change K.
- btn_up, btn_down, btn_left, btn_right  in  1 each  one-cycle debounced pulses.
- btn_commit, btn_undo, btn_clear  in  1 each  one-cycle pulses.
- current_center_x  out  9  preview centre x.
- current_center_y  out  8  preview centre y.
- current_R  out  8  preview radius.
- current_K  out  8  preview strength.
- preview_enable  out  1  preview visible.
- lens_count  out  $clog2(MAX_LENS+1)  committed entries in the display table.
- lens_center_x[0:MAX_LENS-1]  out  9 each  display table.
- lens_center_y[0:MAX_LENS-1]  out  8 each  display table.
- lens_R[0:MAX_LENS-1]  out  8 each  display table.
- lens_K[0:MAX_LENS-1]  out  8 each  display table.
- busy  out  1  clear or check in progress.
- commit_reject  out  1  one-cycle pulse on a refused commit.

Behaviour:
- Reset (reset=0 at a clk edge):
  - current_center_x=IMG_WIDTH/2, current_center_y=IMG_HEIGHT/2, R=R_DEFAULT, K=K_DEFAULT.
  - Working and display tables all zero; lens_count=0.
  - preview_enable=0, busy=0, commit_reject=0.
  - FSM returns to IDLE from any state; pending flags and sync_pending cleared.
- Arrow buttons:
  - Each pulse sets a pending flag; pulses with sw0_edit_mode=0 are dropped.
  - On frame_tick, all pending flags are applied at once, then cleared; this updates `current_*` at tick+1.
  - Opposing flags both set (up+down or left+right): the two cancel, no change.
  - Size mode: R ±R_STEP saturating to [R_MIN,R_MAX]; K ±1 saturating to [0,K_MAX]; left decreases K.
  - Position mode: x ±POS_STEP saturating to [0,IMG_WIDTH-1]; y ±POS_STEP saturating to [0,IMG_HEIGHT-1]; no wrap.
- preview_enable is loaded from sw0_edit_mode on frame_tick only.
- FSM states: IDLE, CLEAR, CHECK (CHECK is reachable only with the optional feature).
- IDLE command priority within one cycle: clear > undo > commit; lower-priority pulses that cycle are dropped.
- Commit (IDLE, edit=1, wcount<MAX_LENS):
  - Working entry[wcount] ← current values at cycle N+1; wcount increments.
  - Same-cycle arrow updates are not included (they are pending until frame_tick).
  - wcount==MAX_LENS or edit=0: table unchanged, commit_reject=1 at N+1.
- Undo (IDLE, wcount>0): wcount decrements and the vacated entry is zeroed at N+1. wcount==0: no-op, no reject.
- Clear (IDLE, any mode):
  - Enters CLEAR with busy=1; zeroes entry i=0..MAX_LENS-1, one per cycle.
  - Then sets wcount=0 and returns to IDLE; total MAX_LENS cycles busy.
  - Commit/undo/clear pulses while busy are dropped; commit additionally pulses commit_reject.
- Display sync:
  - On frame_tick in IDLE: display table and lens_count ← working copy, visible at tick+1.
  - frame_tick while busy sets sync_pending; the copy then occurs on the first IDLE cycle, i.e. the cycle after the last busy cycle.
  - A command pulse coinciding with the copy cycle: the copy takes the pre-command working state.
- Unused display entries (index ≥ lens_count) are always zero.
- All outputs registered; no combinational input-to-output paths.

Optional Feature:
- LENS_OVERLAP_CHECK_EN defined: an accepted commit enters CHECK (busy=1), comparing against one working entry per cycle.
  - Overlap rule: |dx| < R_new+R_i AND |dy| < R_new+R_i, computed in 10-bit unsigned.
  - Any overlap: no write, commit_reject=1 on the exit cycle.
  - No overlap: write on the exit cycle.
  - Latency is max(wcount,1)+1 cycles.
- LENS_OVERLAP_CHECK_EN undefined: CHECK state absent, commit writes at N+1, overlaps allowed.

Test Plan:
- Reset held 3 cycles, release → current=(160,120,R40,K4), lens_count=0, preview_enable=0, all table entries 0.
- Edit=1, position mode, btn_right ×1 then frame_tick → current_center_x=162 at tick+1; with x=318, btn_right+tick → x=319 (saturate); up+down same frame → y unchanged.
- Edit=1, 8 commits → lens_count=8 only after the next frame_tick; 9th commit → commit_reject pulse, count stays 8; undo+tick → count 7, entry[7]=0.
- btn_clear, then frame_tick 2 cycles later → busy high 8 cycles, display unchanged until the cycle after busy falls, then lens_count=0.
- Edit=1, size mode: 60 up pulses across ticks → R saturates at 120; left ×5 from K=4 → K=0.
- With LENS_OVERLAP_CHECK_EN: commit (100,100,R40), move to (150,100), commit → reject; move to (200,100), commit → accepted, count 2 after tick.
